// File: rtl/sos_pkg.sv
// rtl/sos_pkg.sv - shared symbol, letter and sequence-state encodings for the SOS sequencer
package sos_pkg;

  // Symbol codes as produced by the dash/dot classifier
  typedef enum logic [1:0] {
    SYM_DOT     = 2'b00,
    SYM_INVALID = 2'b01,
    SYM_SPACE   = 2'b10,
    SYM_DASH    = 2'b11
  } sym_code_e;

  // Classified letter codes; NONE is what the bus reads between strobes
  typedef enum logic [1:0] {
    LETTER_NONE  = 2'b00,
    LETTER_S     = 2'b01,
    LETTER_O     = 2'b10,
    LETTER_OTHER = 2'b11
  } letter_code_e;

  // Progress through the S-O-S pattern
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'b00,
    SEQ_GOT_S  = 2'b01,
    SEQ_GOT_SO = 2'b10
  } seq_state_e;

  // Symbol count saturates here; anything that reached it is an overflowed letter
  localparam logic [2:0] SYM_COUNT_MAX = 3'd4;

  // Timeout counter width covers the full legal TIMEOUT_CYCLES range
  localparam int unsigned TIMER_W = 16;

  // Exactly three dots is S, exactly three dashes is O, everything else is OTHER.
  // kinds holds the last three marks, 1 = dash, newest in bit 0.
  function automatic logic [1:0] classify_letter(input logic [2:0] count,
                                                 input logic [2:0] kinds);
    logic [1:0] code;
    code = LETTER_OTHER;
    if (count == 3'd3 && kinds == 3'b000) begin
      code = LETTER_S;
    end else if (count == 3'd3 && kinds == 3'b111) begin
      code = LETTER_O;
    end
    return code;
  endfunction

endpackage

// File: rtl/letter_accumulator.sv
// rtl/letter_accumulator.sv - gathers dots/dashes into a letter, closes it on space or idle timeout
module letter_accumulator
  import sos_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sym_valid,
  input  logic [1:0] i_sym_code,
  output logic       o_letter_valid,
  output logic [1:0] o_letter_code,
  output logic       o_open_next
);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);

  logic [2:0]         r_count;
  logic [2:0]         r_kinds;
  logic [TIMER_W-1:0] r_timer;
  logic               r_letter_valid;
  logic [1:0]         r_letter_code;

  logic               w_is_mark;
  logic               w_is_space;
  logic               w_is_invalid;
  logic               w_open;
  logic [TIMER_W-1:0] w_timer_inc;
  logic               w_timeout;
  logic               w_close;
  logic [2:0]         w_count_next;
  logic [2:0]         w_kinds_next;
  logic [TIMER_W-1:0] w_timer_next;

  assign w_is_mark    = i_sym_valid && (i_sym_code == SYM_DOT || i_sym_code == SYM_DASH);
  assign w_is_space   = i_sym_valid && (i_sym_code == SYM_SPACE);
  assign w_is_invalid = i_sym_valid && (i_sym_code == SYM_INVALID);
  assign w_open       = (r_count != 3'd0);
  assign w_timer_inc  = r_timer + TIMER_W'(1);
  // Any symbol in the firing cycle suppresses the timeout, since it only counts idle cycles
  assign w_timeout    = w_open && !i_sym_valid && (w_timer_inc == TIMEOUT_VAL);
  // A space on an empty letter closes nothing
  assign w_close      = (w_is_space && w_open) || w_timeout;

  // Next letter contents: marks append, close/invalid empty it, idle cycles advance the timer
  always_comb begin
    w_count_next = r_count;
    w_kinds_next = r_kinds;
    w_timer_next = r_timer;
    if (w_is_mark) begin
      w_count_next = (r_count == SYM_COUNT_MAX) ? SYM_COUNT_MAX : r_count + 3'd1;
      w_kinds_next = {r_kinds[1:0], (i_sym_code == SYM_DASH)};
      w_timer_next = '0;
    end else if (w_close || w_is_invalid) begin
      w_count_next = 3'd0;
      w_kinds_next = 3'b000;
      w_timer_next = '0;
    end else if (w_open) begin
      w_timer_next = w_timer_inc;
    end
  end

  // Letter state and the registered one-cycle letter strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= 3'd0;
      r_kinds        <= 3'b000;
      r_timer        <= '0;
      r_letter_valid <= 1'b0;
      r_letter_code  <= LETTER_NONE;
    end else begin
      r_count        <= w_count_next;
      r_kinds        <= w_kinds_next;
      r_timer        <= w_timer_next;
      r_letter_valid <= w_close;
      r_letter_code  <= w_close ? classify_letter(r_count, r_kinds) : LETTER_NONE;
    end
  end

  assign o_letter_valid = r_letter_valid;
  assign o_letter_code  = r_letter_code;
  assign o_open_next    = (w_count_next != 3'd0);

endmodule

// File: rtl/sos_sequencer.sv
// rtl/sos_sequencer.sv - detects S-O-S in a classified dot/dash symbol stream and counts detections
module sos_sequencer
  import sos_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym_code,
  output logic             letter_valid,
  output logic [1:0]       letter_code,
  output logic             sos_detected,
  output logic [CNT_W-1:0] sos_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic             r_sos_detected;
  logic [CNT_W-1:0] r_sos_count;
  logic             r_busy;

  logic             w_letter_valid;
  logic [1:0]       w_letter_code;
  logic             w_open_next;
  logic             w_abort;
  logic             w_detect;

  // The classifier's valueReady/dataOut pair drives sym_valid/sym_code directly
  letter_accumulator #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_letter_accumulator (
    .clk           (clk),
    .rst           (rst),
    .i_sym_valid   (sym_valid),
    .i_sym_code    (sym_code),
    .o_letter_valid(w_letter_valid),
    .o_letter_code (w_letter_code),
    .o_open_next   (w_open_next)
  );

  // An invalid symbol aborts the sequence as well as the open letter
  assign w_abort = sym_valid && (sym_code == SYM_INVALID);

  // Sequence state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next sequence state and detection; advances only on a letter strobe, abort wins
  always_comb begin
    w_state_next = r_state;
    w_detect     = 1'b0;
    if (w_abort) begin
      w_state_next = SEQ_IDLE;
    end else if (w_letter_valid) begin
      case (r_state)
        SEQ_IDLE: begin
          if (w_letter_code == LETTER_S) w_state_next = SEQ_GOT_S;
        end
        SEQ_GOT_S: begin
          if (w_letter_code == LETTER_S) begin
            w_state_next = SEQ_GOT_S;
          end else if (w_letter_code == LETTER_O) begin
            w_state_next = SEQ_GOT_SO;
          end else begin
            w_state_next = SEQ_IDLE;
          end
        end
        SEQ_GOT_SO: begin
          // The closing S also opens the next candidate, so SOSOS detects twice
          if (w_letter_code == LETTER_S) begin
            w_state_next = SEQ_GOT_S;
            w_detect     = 1'b1;
          end else begin
            w_state_next = SEQ_IDLE;
          end
        end
        default: w_state_next = SEQ_IDLE;
      endcase
    end
  end

  // Detection pulse, saturating detection counter and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sos_detected <= 1'b0;
      r_sos_count    <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_sos_detected <= w_detect;
      if (w_detect && r_sos_count != CNT_MAX) begin
        r_sos_count <= r_sos_count + CNT_ONE;
      end
      r_busy <= w_open_next || (w_state_next != SEQ_IDLE);
    end
  end

  assign letter_valid = w_letter_valid;
  assign letter_code  = w_letter_code;
  assign sos_detected = r_sos_detected;
  assign sos_count    = r_sos_count;
  assign busy         = r_busy;

endmodule
